// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encoding, parity selector and line-level bit constants.
package uart_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Edge/bit counters for the oversampled line plus the 3-sample mid-bit majority vote.
module uart_rx_sampler
  import uart_defs::*;
#(
  parameter int unsigned BitCntW = 4
) (
  input  logic               CLK,
  input  logic               rst,
  input  logic               rx_s,
  input  logic               start,
  input  logic               active,
  input  logic [5:0]         prescale,
  output logic               sampled_bit,
  output logic               bit_resolve,
  output logic               bit_wrap,
  output logic [BitCntW-1:0] bit_cnt
);

  logic [5:0] edge_cnt;
  logic [5:0] half;
  logic [2:0] samples;

  assign half        = {1'b0, prescale[5:1]};
  assign bit_wrap    = active && (edge_cnt == prescale - 6'd1);
  assign bit_resolve = active && (edge_cnt == half + 6'd2);
  assign sampled_bit = maj3(samples);

  // The start-detect cycle counts as edge 0, so the counter is 1 on the first START cycle.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (start) begin
      edge_cnt <= 6'd1;
      bit_cnt  <= '0;
    end else if (active) begin
      if (bit_wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else begin
        edge_cnt <= edge_cnt + 6'd1;
      end
    end else begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      samples <= '0;
    end else if (active) begin
      if (edge_cnt == half - 6'd1) samples[0] <= rx_s;
      if (edge_cnt == half)        samples[1] <= rx_s;
      if (edge_cnt == half + 6'd1) samples[2] <= rx_s;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: line synchroniser, frame FSM, shift register, parity/stop checks and output registers.
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             CLK,
  input  logic             rst,
  input  logic             RX_IN,
  input  logic [5:0]       Prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [Width-1:0] P_data,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             Busy
);

  localparam int unsigned BitCntW = $clog2(Width + 4);

  rx_state_e          state, next_state;
  logic               sync1, rx_s;
  logic               armed;
  logic               start_det, active;
  logic               sampled_bit, bit_resolve, bit_wrap;
  logic [BitCntW-1:0] bit_cnt;
  logic [Width-1:0]   shift_reg;
  logic               par_en_q, par_typ_q, par_flag;
  logic               par_exp;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_BIT;
      rx_s  <= IDLE_BIT;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
    end
  end

  // A new start needs the line seen high while idle, so a break cannot retrigger.
  assign start_det = (state == ST_IDLE) && armed && (rx_s == START_BIT);
  assign active    = (state != ST_IDLE);
  assign Busy      = active;
  assign par_exp   = (^shift_reg) ^ (par_typ_q == PAR_ODD);

  uart_rx_sampler #(.BitCntW(BitCntW)) u_sampler (
    .CLK         (CLK),
    .rst         (rst),
    .rx_s        (rx_s),
    .start       (start_det),
    .active      (active),
    .prescale    (Prescale),
    .sampled_bit (sampled_bit),
    .bit_resolve (bit_resolve),
    .bit_wrap    (bit_wrap),
    .bit_cnt     (bit_cnt)
  );

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (start_det) next_state = ST_START;
      ST_START: begin
        if (bit_resolve && (sampled_bit != START_BIT)) next_state = ST_IDLE;
        else if (bit_wrap)                             next_state = ST_DATA;
      end
      ST_DATA:   if (bit_wrap && (bit_cnt == BitCntW'(Width)))
                   next_state = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY: if (bit_wrap) next_state = ST_STOP;
      ST_STOP:   if (bit_resolve) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      shift_reg  <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= PAR_EVEN;
      par_flag   <= 1'b0;
      P_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      armed      <= (state == ST_IDLE) && (armed || (rx_s == IDLE_BIT));
      case (state)
        ST_START: begin
          par_flag <= 1'b0;
          if (bit_wrap) begin
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
          end
        end
        ST_DATA: if (bit_resolve) shift_reg <= {sampled_bit, shift_reg[Width-1:1]};
        ST_PARITY: if (bit_resolve && (sampled_bit != par_exp)) par_flag <= 1'b1;
        ST_STOP: begin
          if (bit_resolve) begin
            if ((sampled_bit == STOP_BIT) && !par_flag) begin
              P_data     <= shift_reg;
              data_valid <= 1'b1;
            end
            stp_err  <= (sampled_bit != STOP_BIT);
            par_err  <= par_flag;
            par_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized traffic against a frame-level model.
module tb_uart_rx;

  logic       CLK;
  logic       rst;
  logic       RX_IN;
  logic [5:0] Prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic       Busy;

  uart_rx #(.Width(8)) dut (
    .CLK        (CLK),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .Prescale   (Prescale),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_data     (P_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .Busy       (Busy)
  );

  typedef struct {
    int unsigned cyc;
    logic [2:0]  kind;  // {stp_err, par_err, data_valid}
    logic [7:0]  data;
    logic        busy;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         got_q[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  logic [7:0]  model_pdata = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (data_valid || par_err || stp_err)
      got_q.push_back('{cyc, {stp_err, par_err, data_valid}, P_data, Busy});
  end

  initial begin
    #50_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int unsigned n);
    RX_IN = b;
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle(input int unsigned n);
    drive_bit(1'b1, n);
  endtask

  // Frame-level model: outcome and timing follow from the frame contents alone.
  task automatic send_frame(input logic [7:0] d, input bit pe, input bit ptyp,
                            input bit flip, input bit stop_b);
    ev_t         e;
    bit          pbit;
    bit          ok;
    int unsigned p;
    p       = Prescale;
    PAR_EN  = pe;
    PAR_TYP = ptyp;
    pbit    = (($countones(d) % 2) == 1) ^ ptyp ^ flip;
    ok      = !(pe && flip);
    e.cyc   = cyc + 3 + (9 + int'(pe)) * p + p / 2 + 2;
    e.kind  = {!stop_b, !ok, stop_b && ok};
    if (stop_b && ok) model_pdata = d;
    e.data  = model_pdata;
    e.busy  = 1'b0;
    exp_q.push_back(e);
    drive_bit(1'b0, p);
    check("busy_mid", Busy, 1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(pbit, p);
    drive_bit(stop_b, p);
  endtask

  task automatic drain(input string tag);
    ev_t g, x;
    check({tag, ":events"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      check({tag, ":kind"}, g.kind, x.kind);
      check({tag, ":cycle"}, g.cyc, x.cyc);
      check({tag, ":pdata"}, g.data, x.data);
      check({tag, ":busy"}, g.busy, x.busy);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    rst = 1'b0; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_pdata", P_data, 0);
    check("rst_valid", data_valid, 0);
    check("rst_par", par_err, 0);
    check("rst_stp", stp_err, 0);
    check("rst_busy", Busy, 0);
    rst = 1'b1;
    idle(5);

    Prescale = 6'd8;
    send_frame(8'hA5, 0, 0, 0, 1);
    idle(20); drain("t1");

    Prescale = 6'd16;
    send_frame(8'h3C, 1, 0, 0, 1);
    send_frame(8'h3C, 1, 0, 1, 1);
    idle(40); drain("t2");

    Prescale = 6'd32;
    send_frame(8'h81, 0, 0, 0, 0);
    idle(80); drain("t3");
    check("t3_busy", Busy, 0);

    Prescale = 6'd16;
    drive_bit(1'b0, 3);
    check("glitch_busy_hi", Busy, 1);
    idle(40);
    check("glitch_busy_lo", Busy, 0);
    drain("t4");

    Prescale = 6'd8;
    send_frame(8'h00, 0, 0, 0, 1);
    send_frame(8'hFF, 0, 0, 0, 1);
    send_frame(8'h55, 0, 0, 0, 1);
    idle(20); drain("t5");

    send_frame(8'h00, 0, 0, 0, 0);
    drive_bit(1'b0, 24);
    check("break_busy", Busy, 0);
    idle(20); drain("brk");
    send_frame(8'h5A, 0, 0, 0, 1);
    idle(20); drain("brk_after");

    d = 8'hC3;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    drive_bit(d[4], 4);
    rst = 1'b0;
    #1;
    check("mrst_pdata", P_data, 0);
    check("mrst_valid", data_valid, 0);
    check("mrst_par", par_err, 0);
    check("mrst_stp", stp_err, 0);
    check("mrst_busy", Busy, 0);
    model_pdata = 8'h00;
    idle(5);
    rst = 1'b1;
    idle(5);
    drain("mrst");
    send_frame(8'h12, 0, 0, 0, 1);
    idle(20); drain("t6");

    for (int g = 0; g < 6; g++) begin
      int unsigned sel;
      sel = $urandom_range(0, 2);
      Prescale = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : 6'd32;
      for (int f = 0; f < 5; f++) begin
        bit pe, ptyp, flip, stop_b;
        pe     = 1'($urandom_range(0, 1));
        ptyp   = 1'($urandom_range(0, 1));
        flip   = pe && ($urandom_range(0, 3) == 0);
        stop_b = ($urandom_range(0, 4) != 0);
        send_frame(8'($urandom), pe, ptyp, flip, stop_b);
        idle(stop_b ? $urandom_range(0, 10) : $urandom_range(2, 10));
      end
      idle(2 * int'(Prescale));
      drain("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
